// File: rtl/counter_sequencer.sv
// Programmable up/down counter sequencer.
// A sequence is armed from IDLE with start, counts from the captured load
// value toward the captured terminal value, and either finishes through a
// one-cycle DONE state or reloads and keeps running. Every output comes from
// a register or is decoded from the registered state.
module counter_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] term_val,
    input  logic             dir,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic [1:0]       state,
    output logic             busy,
    output logic             done,
    output logic             tc_pulse
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t           cur_state;
    state_t           nxt_state;
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] nxt_count;
    logic             tc_r;
    logic             nxt_tc;
    logic             capture;

    // Configuration captured on the arming edge; later input changes are ignored
    logic [WIDTH-1:0] load_cfg;
    logic [WIDTH-1:0] term_cfg;
    logic             dir_cfg;
    logic             reload_cfg;

    // Next counter value when stepping; arithmetic wraps modulo 2^WIDTH
    logic [WIDTH-1:0] step_val;
    assign step_val = dir_cfg ? (count_r - WIDTH'(1)) : (count_r + WIDTH'(1));

    // State, counter and reload-pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= IDLE;
            count_r   <= '0;
            tc_r      <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            count_r   <= nxt_count;
            tc_r      <= nxt_tc;
        end
    end

    // Configuration capture when a sequence is armed from IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_cfg   <= '0;
            term_cfg   <= '0;
            dir_cfg    <= 1'b0;
            reload_cfg <= 1'b0;
        end else if (capture) begin
            load_cfg   <= load_val;
            term_cfg   <= term_val;
            dir_cfg    <= dir;
            reload_cfg <= auto_reload;
        end
    end

    // Next-state and counter decisions; priority is abort > pause > terminal > step
    always_comb begin
        nxt_state = cur_state;
        nxt_count = count_r;
        nxt_tc    = 1'b0;
        capture   = 1'b0;
        if (abort) begin
            nxt_state = IDLE;
            nxt_count = '0;
        end else begin
            case (cur_state)
                IDLE: begin
                    // pause is irrelevant here; start always arms
                    if (start) begin
                        capture   = 1'b1;
                        nxt_count = load_val;
                        nxt_state = RUN;
                    end
                end
                RUN: begin
                    if (pause) begin
                        nxt_state = PAUSE;
                    end else if (count_r == term_cfg) begin
                        if (reload_cfg) begin
                            // Pulse lines up with the cycle showing the reloaded value
                            nxt_count = load_cfg;
                            nxt_tc    = 1'b1;
                        end else begin
                            nxt_state = DONE;
                        end
                    end else begin
                        nxt_count = step_val;
                    end
                end
                PAUSE: begin
                    if (start) begin
                        nxt_state = RUN;
                    end
                end
                DONE: begin
                    // Count keeps the terminal value on the way back to IDLE
                    nxt_state = IDLE;
                end
                default: begin
                    nxt_state = IDLE;
                end
            endcase
        end
    end

    assign count    = count_r;
    assign state    = cur_state;
    assign busy     = (cur_state == RUN) || (cur_state == PAUSE);
    assign done     = (cur_state == DONE);
    assign tc_pulse = tc_r;

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench for counter_sequencer: a driver applies directed and
// random stimulus and queues the outputs a behavioural model predicts; a
// separate monitor pops and compares them after every rising edge.
module tb_counter_sequencer;

    localparam int W   = 4;
    localparam int MOD = 1 << W;

    // Model state numbering follows the visible state port encoding
    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_DONE  = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         pause;
    logic         abort;
    logic [W-1:0] load_val;
    logic [W-1:0] term_val;
    logic         dir;
    logic         auto_reload;
    logic [W-1:0] count;
    logic [1:0]   state;
    logic         busy;
    logic         done;
    logic         tc_pulse;

    counter_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .abort(abort),
        .load_val(load_val), .term_val(term_val), .dir(dir),
        .auto_reload(auto_reload), .count(count), .state(state),
        .busy(busy), .done(done), .tc_pulse(tc_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        int count;
        int state;
        int busy;
        int done;
        int tc;
    } exp_t;

    exp_t q[$];
    int   tests    = 0;
    int   failures = 0;
    bit   finished = 0;

    // Behavioural model of the sequence
    int m_state, m_count, m_load, m_term, m_dir, m_ar, m_tc;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t snapshot();
        exp_t e;
        e.count = m_count;
        e.state = m_state;
        e.busy  = (m_state == S_RUN || m_state == S_PAUSE) ? 1 : 0;
        e.done  = (m_state == S_DONE) ? 1 : 0;
        e.tc    = m_tc;
        return e;
    endfunction

    task automatic model_reset();
        m_state = S_IDLE; m_count = 0; m_tc = 0;
        m_load = 0; m_term = 0; m_dir = 0; m_ar = 0;
    endtask

    // What one clock edge does to the sequence, given the inputs held across it
    task automatic model_edge(input bit st, input bit pa, input bit ab,
                              input int lv, input int tv, input bit d, input bit ar);
        int ns, nc, ntc;
        ns = m_state; nc = m_count; ntc = 0;
        if (ab) begin
            ns = S_IDLE; nc = 0;
        end else if (m_state == S_IDLE) begin
            if (st) begin
                m_load = lv; m_term = tv; m_dir = d; m_ar = ar;
                nc = lv; ns = S_RUN;
            end
        end else if (m_state == S_RUN) begin
            if (pa) ns = S_PAUSE;
            else if (m_count == m_term) begin
                if (m_ar) begin nc = m_load; ntc = 1; end
                else ns = S_DONE;
            end else begin
                nc = (m_count + (m_dir ? MOD - 1 : 1)) % MOD;
            end
        end else if (m_state == S_PAUSE) begin
            if (st) ns = S_RUN;
        end else begin
            ns = S_IDLE;
        end
        m_state = ns; m_count = nc; m_tc = ntc;
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        check({tag, ".count"}, int'(count), e.count);
        check({tag, ".state"}, int'(state), e.state);
        check({tag, ".busy"},  int'(busy),  e.busy);
        check({tag, ".done"},  int'(done),  e.done);
        check({tag, ".tc"},    int'(tc_pulse), e.tc);
    endtask

    // One cycle of stimulus: inputs change on the falling edge
    task automatic cyc(input bit r, input bit st, input bit pa, input bit ab,
                       input int lv, input int tv, input bit d, input bit ar);
        @(negedge clk);
        rst_n = r; start = st; pause = pa; abort = ab;
        load_val = W'(lv); term_val = W'(tv); dir = d; auto_reload = ar;
        if (!r) begin
            model_reset();
            #1;
            check_outputs("async_reset", snapshot());
        end else begin
            model_edge(st, pa, ab, lv, tv, d, ar);
        end
        q.push_back(snapshot());
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, $urandom_range(0, MOD - 1), $urandom_range(0, MOD - 1), $urandom_range(0, 1), $urandom_range(0, 1));
    endtask

    // Monitor: compare DUT outputs against the queued predictions after each edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (finished) break;
            if (q.size() == 0) begin
                check("scoreboard_underflow", 1, 0);
            end else begin
                check_outputs("cycle", q.pop_front());
            end
        end
    end

    // Driver
    initial begin
        rst_n = 1'b0; start = 0; pause = 0; abort = 0;
        load_val = '0; term_val = '0; dir = 0; auto_reload = 0;
        model_reset();
        #1;
        check_outputs("reset", snapshot());
        q.push_back(snapshot());
        cyc(0, 1, 0, 0, 5, 9, 0, 0);
        cyc(1, 0, 1, 0, 0, 0, 0, 0);

        // Up count 3..7 then DONE then IDLE
        cyc(1, 1, 0, 0, 3, 7, 0, 0);
        idle_cycles(8);

        // Down count with wrap 2,1,0,15,14
        cyc(1, 1, 1, 0, 2, 14, 1, 0);
        idle_cycles(8);

        // Auto-reload 0,1,2,0,... then abort
        cyc(1, 1, 0, 0, 0, 2, 0, 1);
        idle_cycles(10);
        cyc(1, 0, 0, 1, 0, 0, 0, 0);
        idle_cycles(2);

        // Pause at count 5, hold 3 cycles, resume to terminal 9
        cyc(1, 1, 0, 0, 0, 9, 0, 0);
        idle_cycles(5);
        cyc(1, 0, 1, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0, 0, 0);
        idle_cycles(2);
        cyc(1, 1, 0, 0, 0, 0, 0, 0);
        idle_cycles(7);

        // start in DONE ignored; L == T gives one RUN cycle
        cyc(1, 1, 0, 0, 6, 6, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 0);
        idle_cycles(2);

        // abort together with pause in RUN
        cyc(1, 1, 0, 0, 4, 12, 0, 0);
        idle_cycles(2);
        cyc(1, 0, 1, 1, 0, 0, 0, 0);
        idle_cycles(1);

        // Pause exactly at the terminal value, then resume straight into DONE
        cyc(1, 1, 0, 0, 0, 3, 0, 0);
        idle_cycles(3);
        cyc(1, 0, 1, 0, 0, 0, 0, 0);
        idle_cycles(1);
        cyc(1, 1, 0, 0, 0, 0, 0, 0);
        idle_cycles(3);

        // Reset dropped mid-RUN, then a fresh sequence from cold IDLE
        cyc(1, 1, 0, 0, 1, 10, 0, 1);
        idle_cycles(3);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 8, 5, 1, 0);
        idle_cycles(6);

        // Random stimulus
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom_range(0, 199) != 0),
                ($urandom_range(0, 99) < 30),
                ($urandom_range(0, 99) < 12),
                ($urandom_range(0, 99) < 3),
                $urandom_range(0, MOD - 1), $urandom_range(0, MOD - 1),
                $urandom_range(0, 1), $urandom_range(0, 1));
        end

        @(posedge clk);
        #2;
        finished = 1;
        check("scoreboard_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
